// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and timing constants for the multiply/divide unit
package muldiv_pkg;
   typedef enum logic [1:0] {
      MD_MUL  = 2'b00,
      MD_UDIV = 2'b01,
      MD_SDIV = 2'b10,
      MD_RSVD = 2'b11
   } md_op_e;
   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FINISH
   } md_state_e;
   localparam int ITER_COUNT = 64;
   localparam int LATENCY = 65;
endpackage

// File: rtl/mul_div_step.sv
// mul_div_step: one combinational radix-2 iteration (shift-add multiply or restoring divide)
module mul_div_step import muldiv_pkg::*; #(
   parameter int WIDTH = 64
) (
   input  logic                     isDiv,
   input  logic [2*WIDTH-1:0]       acc,
   input  logic [WIDTH-1:0]         multiplicand,
   input  logic [WIDTH-1:0]         operand,
   input  logic [$clog2(WIDTH)-1:0] bitIdx,
   output logic [2*WIDTH-1:0]       accNext,
   output logic                     qBit
);
   logic [2*WIDTH-1:0] shifted, addend;
   logic [WIDTH:0] trial;
   // divide: acc = {remainder, remaining dividend bits}; the shifted remainder needs one extra bit
   assign shifted = {acc[2*WIDTH-2:0], 1'b0};
   assign trial = {acc[2*WIDTH-1], shifted[2*WIDTH-1:WIDTH]} - {1'b0, operand};
   assign qBit = isDiv & ~trial[WIDTH];
   assign addend = operand[bitIdx] ? {{WIDTH{1'b0}}, multiplicand} << bitIdx : '0;
   assign accNext = !isDiv ? acc + addend : qBit ? {trial[WIDTH-1:0], shifted[WIDTH-1:0]} : shifted;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MUL/UDIV/SDIV with a fixed 65-cycle start-to-done latency
module mul_div_unit import muldiv_pkg::*; #(
   parameter int WIDTH = 64,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [WIDTH-1:0]      operand_a,
   input  logic [WIDTH-1:0]      operand_b,
   input  logic [REG_ADDR_W-1:0] rd_in,
   output logic                  busy,
   output logic                  done,
   output logic [WIDTH-1:0]      result,
   output logic [REG_ADDR_W-1:0] rd_out
);
   localparam int CW = $clog2(WIDTH);
   md_state_e state;
   md_op_e opReg;
   logic [2*WIDTH-1:0] acc, stepAcc;
   logic [WIDTH-1:0] aReg, bReg, aMag, bMag, quot, fixed;
   logic [CW-1:0] count;
   logic [REG_ADDR_W-1:0] rdReg;
   logic negQ, aNeg, bNeg, isMul, qBit;
   assign isMul = op == MD_MUL;
   assign aNeg = op == MD_SDIV && operand_a[WIDTH-1];
   assign bNeg = op == MD_SDIV && operand_b[WIDTH-1];
   // the most-negative value negates to itself, which read unsigned is exactly 2^(WIDTH-1)
   assign aMag = aNeg ? -operand_a : operand_a;
   assign bMag = bNeg ? -operand_b : operand_b;
   assign quot = acc[WIDTH-1:0];
   assign fixed = opReg == MD_MUL ? quot :
                  (opReg == MD_RSVD || bReg == '0) ? '0 :
                  (opReg == MD_SDIV && negQ) ? -quot : quot;
   mul_div_step #(.WIDTH(WIDTH)) step (
      .isDiv       (opReg != MD_MUL),
      .acc         (acc),
      .multiplicand(aReg),
      .operand     (bReg),
      .bitIdx      (count),
      .accNext     (stepAcc),
      .qBit        (qBit)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         rd_out <= '0;
         count  <= '0;
         acc    <= '0;
         opReg  <= MD_MUL;
         aReg   <= '0;
         bReg   <= '0;
         rdReg  <= '0;
         negQ   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == RUN) begin
            acc   <= {stepAcc[2*WIDTH-1:1], stepAcc[0] | qBit};
            count <= count + 1'b1;
            if (count == CW'(ITER_COUNT - 1)) begin
               state <= FINISH;
               busy  <= 1'b0;
            end
         end
         if (state == FINISH) begin
            result <= fixed;
            rd_out <= rdReg;
            done   <= 1'b1;
            state  <= IDLE;
         end
         // busy drops on entry to FINISH so a request can overlap the done cycle
         if (!busy && start) begin
            opReg <= md_op_e'(op);
            aReg  <= operand_a;
            bReg  <= isMul ? operand_b : bMag;
            acc   <= isMul ? '0 : {{WIDTH{1'b0}}, aMag};
            negQ  <= aNeg ^ bNeg;
            rdReg <= rd_in;
            count <= '0;
            state <= RUN;
            busy  <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed scoreboard bench for the multiply/divide unit
module tb_mul_div_unit;
   import muldiv_pkg::*;
   localparam int W = 64;
   localparam logic [W-1:0] M100 = 64'hFFFF_FFFF_FFFF_FF9C;
   localparam logic [W-1:0] M7   = 64'hFFFF_FFFF_FFFF_FFF9;
   localparam logic [W-1:0] M14  = 64'hFFFF_FFFF_FFFF_FFF2;
   localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [W-1:0] MINV = 64'h8000_0000_0000_0000;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [1:0] op = 2'b00;
   logic [W-1:0] operand_a = '0, operand_b = '0;
   logic [4:0] rd_in = '0;
   logic busy, done;
   logic [W-1:0] result;
   logic [4:0] rd_out;
   int cyc = 0, checks = 0, fails = 0;
   typedef struct {
      logic [W-1:0] res;
      logic [4:0]   rd;
   } exp_t;
   exp_t sb[$];

   mul_div_unit dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in),
      .busy(busy), .done(done), .result(result), .rd_out(rd_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] rd, input logic [W-1:0] res, output int e0);
      @(negedge clk);
      start = 1'b1; op = o; operand_a = a; operand_b = b; rd_in = rd;
      sb.push_back('{res, rd});
      @(posedge clk); #1;
      e0 = cyc;
      start = 1'b0;
   endtask

   task automatic checkDone(input string tag, input int e0);
      exp_t e;
      check({tag, " done"}, 64'(done), 64'd1);
      if (sb.size() == 0) begin
         check({tag, " scoreboard empty"}, 64'(sb.size()), 64'd1);
      end else begin
         e = sb.pop_front();
         check({tag, " latency"}, 64'(cyc - e0), 64'(LATENCY));
         check({tag, " result"}, result, e.res);
         check({tag, " rd_out"}, 64'(rd_out), 64'(e.rd));
      end
   endtask

   task automatic waitDone(input string tag, input int e0);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (done !== 1'b1 && n < 200);
      checkDone(tag, e0);
      @(posedge clk); #1;
      check({tag, " single pulse"}, 64'(done), 64'd0);
   endtask

   task automatic waitUntil(input int c);
      while (cyc < c) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic countDones(input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         @(posedge clk); #1;
         if (done) n++;
      end
   endtask

   initial begin
      int e0, e1, n;
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset result", result, 64'd0);
      check("reset rd_out", 64'(rd_out), 64'd0);
      reset = 1'b0;

      issue(MD_MUL, 64'd7, 64'd6, 5'd3, 64'd42, e0);
      check("mul busy after E0", 64'(busy), 64'd1);
      waitDone("mul 7x6", e0);
      issue(MD_MUL, ONES, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFE, e0);
      waitDone("mul ones x2", e0);
      issue(MD_UDIV, 64'd100, 64'd7, 5'd5, 64'd14, e0);
      waitDone("udiv 100/7", e0);
      issue(MD_SDIV, M100, 64'd7, 5'd6, M14, e0);
      waitDone("sdiv -100/7", e0);
      issue(MD_SDIV, 64'd100, M7, 5'd7, M14, e0);
      waitDone("sdiv 100/-7", e0);
      issue(MD_SDIV, M100, M7, 5'd8, 64'd14, e0);
      waitDone("sdiv -100/-7", e0);
      issue(MD_UDIV, 64'd5, 64'd0, 5'd9, 64'd0, e0);
      waitDone("udiv 5/0", e0);
      issue(MD_SDIV, 64'd5, 64'd0, 5'd10, 64'd0, e0);
      waitDone("sdiv 5/0", e0);
      issue(MD_SDIV, MINV, ONES, 5'd11, MINV, e0);
      waitDone("sdiv min/-1", e0);
      issue(MD_UDIV, ONES, 64'd1, 5'd12, ONES, e0);
      waitDone("udiv max/1", e0);
      issue(MD_RSVD, 64'd9, 64'd3, 5'd13, 64'd0, e0);
      waitDone("reserved op", e0);

      issue(MD_MUL, 64'd3, 64'd4, 5'd14, 64'd12, e0);
      waitUntil(e0 + 9);
      @(negedge clk);
      start = 1'b1; op = MD_UDIV; operand_a = 64'd9; operand_b = 64'd3; rd_in = 5'd15;
      @(posedge clk); #1;
      start = 1'b0;
      check("ignored start busy", 64'(busy), 64'd1);
      waitDone("ignored start", e0);
      countDones(70, n);
      check("ignored start no second done", 64'(n), 64'd0);

      issue(MD_MUL, 64'd7, 64'd6, 5'd16, 64'd42, e0);
      waitUntil(e0 + 64);
      @(negedge clk);
      start = 1'b1; op = MD_UDIV; operand_a = 64'd100; operand_b = 64'd7; rd_in = 5'd17;
      sb.push_back('{64'd14, 5'd17});
      @(posedge clk); #1;
      start = 1'b0;
      e1 = cyc;
      checkDone("b2b first", e0);
      check("b2b busy", 64'(busy), 64'd1);
      waitDone("b2b second", e1);

      issue(MD_SDIV, M100, 64'd7, 5'd18, M14, e0);
      waitUntil(e0 + 29);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      sb.delete();
      check("mid reset busy", 64'(busy), 64'd0);
      check("mid reset done", 64'(done), 64'd0);
      check("mid reset result", result, 64'd0);
      check("mid reset rd_out", 64'(rd_out), 64'd0);
      countDones(80, n);
      check("mid reset no done", 64'(n), 64'd0);

      @(negedge clk);
      reset = 1'b1; start = 1'b1; op = MD_MUL; operand_a = 64'd5; operand_b = 64'd5; rd_in = 5'd19;
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      check("reset+start busy", 64'(busy), 64'd0);
      countDones(70, n);
      check("reset+start no done", 64'(n), 64'd0);

      issue(MD_MUL, 64'd2, 64'd2, 5'd20, 64'd4, e0);
      waitDone("mul 2x2 after reset", e0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative multi-cycle 64-bit multiply/divide unit directly downstream of the register file. Consumes the two register read operands (readData1/readData2) and produces a result plus destination tag. These feed back into the register file write port (writeData/writeRegister) under the done strobe. Implements MUL (low 64 bits), UDIV and SDIV (quotient only) with a fixed latency and a start/busy/done handshake.

Parameters:
WIDTH, 64, operand and result width in bits.
REG_ADDR_W, 5, destination register tag width.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only while busy=0.
op  input  2  operation select, encoding from muldiv_pkg.
operand_a  input  WIDTH  multiplicand / dividend (from readData1).
operand_b  input  WIDTH  multiplier / divisor (from readData2).
rd_in  input  REG_ADDR_W  destination register of the request.
busy  output  1  high while an operation is in flight.
done  output  1  one-cycle strobe; result and rd_out valid in that cycle; drives regWrite.
result  output  WIDTH  result; held until the next done.
rd_out  output  REG_ADDR_W  destination tag captured at start; held with result.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset. A reset-high cycle takes effect at that rising edge, with no asynchronous path.
- Reset values: busy=0, done=0, result=0, rd_out=0, state=IDLE, iteration counter=0.
- FSM states: IDLE, RUN, FINISH.
  - IDLE: on an edge with start=1, latch op, operand_a, operand_b and rd_in, init accumulator and counter, go to RUN, busy=1.
  - RUN: one radix-2 iteration per edge, counter 0..63. After the edge where counter=63 completes, go to FINISH.
  - FINISH: apply sign fix-up, register result and rd_out, set done=1 for one cycle, set busy=0, go to IDLE.
- Latency: if start is sampled at edge E0, iterations occur at E1..E64 and result/done update at E65. done is high between E65 and E66.
  - Latency is fixed at 65 cycles for every op and operand value; there are no early exits.
- Back-to-back: a start sampled at E65, while done is high and busy=0, is accepted. Throughput is one op per 65 cycles.
- start while busy=1 is ignored; the latched operands are not disturbed.
- done is never asserted except from FINISH.
- MUL: shift-add over the bits of operand_b with a 2*WIDTH accumulator. result = low WIDTH bits of the product. Signed and unsigned give identical low bits.
- UDIV: restoring division, quotient truncated.
- SDIV:
  - Divide the magnitudes.
  - Quotient is negated if sign(a) xor sign(b); this truncates toward zero.
  - Most-negative value / -1 = most-negative value (wraps).
  - Magnitude of the most-negative value is handled as unsigned 2^63.
- Divide by zero (UDIV or SDIV): result=0, same latency, no error flag.
- Reserved op encoding 2'b11: completes normally with result=0.
- Reset mid-operation: at the reset edge, return to IDLE, busy=0 and done=0. The in-flight op is discarded with no done pulse. result and rd_out are cleared to 0.
- Reset coincident with start: reset wins; the request is dropped.

Decomposition:
- muldiv_pkg holds:
  - op typedef: MD_MUL=2'b00, MD_UDIV=2'b01, MD_SDIV=2'b10, MD_RSVD=2'b11.
  - state typedef for IDLE/RUN/FINISH.
  - constants ITER_COUNT=64 and LATENCY=65.
- One sub-module, mul_div_step: purely combinational single iteration. It takes op class, accumulator, operand and bit index, and returns the next accumulator and quotient bit. The top level keeps the FSM, counter, operand registers and sign fix-up.

Test Plan:
- MUL 7 x 6, rd_in=3 -> busy high from E0; done exactly at E65 with result=42, rd_out=3. Then MUL 0xFFFFFFFFFFFFFFFF x 2 -> result=0xFFFFFFFFFFFFFFFE.
- UDIV 100/7 -> 14. SDIV -100/7 -> 0xFFFFFFFFFFFFFFF2 (-14). SDIV 100/-7 -> -14. SDIV -100/-7 -> 14.
- Boundary cases:
  - UDIV 5/0 -> 0.
  - SDIV 5/0 -> 0.
  - SDIV 0x8000000000000000/-1 -> 0x8000000000000000.
  - UDIV 0xFFFFFFFFFFFFFFFF/1 -> 0xFFFFFFFFFFFFFFFF.
- Start MUL 3x4; pulse start with UDIV 9/3 at E10 -> ignored. Single done at E65 with result=12; no second done.
- Start asserted at E65 alongside done -> accepted; second done at E130 with the second op's correct result.
- Reset at E30 of an in-flight SDIV -> busy=0, done=0, result=0 after E30; no done ever appears. A fresh MUL 2x2 started afterwards returns 4 at +65.
